// File: rtl/btn_toggle_debounce_pkg.sv
// Shared definitions for the push-button debounce front end.
//   state_e      : debounce FSM states (2-bit encoding)
//   PM_*         : edge-selection constants for PULSE_MODE
//   pulseEnabled : true when a qualified edge of the given direction
//                  should produce a t_pulse under the given mode
package btn_toggle_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  localparam int PM_PRESS   = 0;
  localparam int PM_RELEASE = 1;
  localparam int PM_BOTH    = 2;

  function automatic logic pulseEnabled(input int mode, input logic rising);
    if (mode == PM_BOTH) return 1'b1;
    if (rising)          return (mode == PM_PRESS);
    return (mode == PM_RELEASE);
  endfunction

endpackage

// File: rtl/btn_toggle_debounce_if.sv
// Signal bundle between a raw button source and the debounce stage.
//   btn_in    : raw, asynchronous, bouncing button level
//   t_pulse   : one-cycle pulse per qualified edge (feeds a toggle FF's t)
//   btn_level : debounced button level
//   busy      : a candidate level change is being qualified
// slave  = debounce stage view, master = button/consumer side view.
interface btn_toggle_debounce_if;
  logic btn_in;
  logic t_pulse;
  logic btn_level;
  logic busy;

  modport slave  (input  btn_in, output t_pulse, output btn_level, output busy);
  modport master (output btn_in, input  t_pulse, input  btn_level, input  busy);
endinterface

// File: rtl/btn_toggle_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous, active-low reset (both flops clear to 0)
//   d   : asynchronous input
//   q   : synchronised output, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/btn_toggle_debounce.sv
// Push-button front end: synchronise, debounce with a stability counter,
// and emit a single-cycle t_pulse per qualified edge.
//   clk : system clock, all state on the rising edge
//   rst : asynchronous, active-low reset
//   bus : btn_toggle_debounce_if.slave (btn_in in; t_pulse, btn_level, busy out)
// Parameters:
//   DEBOUNCE_CYCLES : consecutive synchronised samples needed to accept a change (>= 2)
//   PULSE_MODE      : PM_PRESS, PM_RELEASE or PM_BOTH
module btn_toggle_debounce
  import btn_toggle_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_MODE      = PM_PRESS
) (
  input  logic                    clk,
  input  logic                    rst,
  btn_toggle_debounce_if.slave    bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s2;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (s2)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // A WAIT state counts consecutive samples at the candidate level; any
  // opposite sample drops back to the idle state with no partial credit.
  // Comparing with >= makes an out-of-range count qualify instead of wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (s2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = pulseEnabled(PULSE_MODE, 1'b1);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!s2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          pulse_d = pulseEnabled(PULSE_MODE, 1'b0);
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.t_pulse   = pulse_q;
  assign bus.btn_level = level_q;
  assign bus.busy      = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_btn_toggle_debounce.sv
// Self-checking bench for btn_toggle_debounce. Three instances (press,
// release and both-edge pulse modes) share one button stimulus; a
// run-length reference model predicts the outputs, and a toggle flip-flop
// driven by the press-mode t_pulse checks the end-to-end toggle behaviour.
module tb_btn_toggle_debounce;

  localparam int DB = 4;

  logic clk;
  logic rst;

  btn_toggle_debounce_if if0 ();
  btn_toggle_debounce_if if1 ();
  btn_toggle_debounce_if if2 ();

  btn_toggle_debounce #(.DEBOUNCE_CYCLES(DB), .PULSE_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  btn_toggle_debounce #(.DEBOUNCE_CYCLES(DB), .PULSE_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  btn_toggle_debounce #(.DEBOUNCE_CYCLES(DB), .PULSE_MODE(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Downstream toggle flip-flop driven by the press-mode pulse.
  logic tffQ;
  logic tffQbar;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tffQ <= 1'b0;
    else if (if0.t_pulse) tffQ <= ~tffQ;
  end
  assign tffQbar = ~tffQ;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the synchroniser is a two-deep delay line of samples;
  // the debounced level flips once DB consecutive visible samples disagree.
  logic s1m, s2m, lvlm, qm;
  int   runm;
  logic pulsem [3];
  int   stepNo;
  int   pulseStep;
  int   pulseCount0;

  task automatic modelReset();
    s1m = 1'b0; s2m = 1'b0; lvlm = 1'b0; qm = 1'b0; runm = 0;
    for (int m = 0; m < 3; m++) pulsem[m] = 1'b0;
  endtask

  task automatic modelStep(input logic b);
    logic v;
    v   = s2m;
    s2m = s1m;
    s1m = b;
    if (pulsem[0]) qm = ~qm;
    for (int m = 0; m < 3; m++) pulsem[m] = 1'b0;
    if (v != lvlm) begin
      runm++;
      if (runm >= DB) begin
        lvlm = v;
        runm = 0;
        pulsem[0] = lvlm;
        pulsem[1] = ~lvlm;
        pulsem[2] = 1'b1;
      end
    end else begin
      runm = 0;
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic expBusy;
    expBusy = (runm != 0);
    checkBit({tag, " level0"}, if0.btn_level, lvlm);
    checkBit({tag, " level1"}, if1.btn_level, lvlm);
    checkBit({tag, " level2"}, if2.btn_level, lvlm);
    checkBit({tag, " busy0"},  if0.busy, expBusy);
    checkBit({tag, " busy1"},  if1.busy, expBusy);
    checkBit({tag, " busy2"},  if2.busy, expBusy);
    checkBit({tag, " pulse0"}, if0.t_pulse, pulsem[0]);
    checkBit({tag, " pulse1"}, if1.t_pulse, pulsem[1]);
    checkBit({tag, " pulse2"}, if2.t_pulse, pulsem[2]);
    checkBit({tag, " tffQ"},    tffQ, qm);
    checkBit({tag, " tffQbar"}, tffQbar, ~qm);
  endtask

  // Drive between edges, advance one clock, then check just after the edge.
  task automatic applyStimulus(input logic b, input string tag);
    if0.btn_in = b; if1.btn_in = b; if2.btn_in = b;
    @(posedge clk);
    modelStep(b);
    stepNo++;
    #1;
    if (if0.t_pulse === 1'b1) begin
      pulseCount0++;
      pulseStep = stepNo;
    end
    checkOutput(tag);
  endtask

  task automatic applyRun(input logic b, input int n, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(b, tag);
  endtask

  // Called 1ns after an edge: assert reset mid-cycle, check the immediate
  // clear, release before the next edge.
  task automatic doReset(input string tag);
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    #3 rst = 1'b1;
  endtask

  initial begin
    stepNo = 0; pulseStep = -1; pulseCount0 = 0;
    modelReset();
    rst = 1'b0;
    if0.btn_in = 1'b1; if1.btn_in = 1'b1; if2.btn_in = 1'b1;

    // Reset held across the first edge with the button already high.
    #3 checkOutput("rst_t3");
    #3 checkOutput("rst_t6");
    #1 rst = 1'b1;

    // Press qualifies 5 edges after the first post-reset edge.
    applyRun(1'b1, 8, "clean_press");
    checks++;
    assert (pulseStep === 6 && pulseCount0 === 1) else begin
      errors++;
      $error("[TB] FAIL press_latency observed step %0d count %0d expected step 6 count 1", pulseStep, pulseCount0);
    end

    // Release: level falls, only release/both modes pulse.
    applyRun(1'b0, 8, "release");

    // Bounce: short high burst is rejected, then a full qualification.
    applyRun(1'b1, 2, "bounce_a");
    applyRun(1'b0, 1, "bounce_b");
    applyRun(1'b1, 8, "bounce_c");
    applyRun(1'b0, 8, "bounce_d");

    // Reset while qualifying a press (count at 2), button stays high.
    applyRun(1'b1, 4, "midq_pre");
    checkBit("midq_busy_before", if0.busy, 1'b1);
    doReset("midq_rst");
    applyRun(1'b1, 8, "midq_post");
    applyRun(1'b0, 8, "midq_rel");

    // Integration: three bouncing presses toggle q 0->1->0->1.
    doReset("tff_rst");
    for (int p = 0; p < 3; p++) begin
      applyRun(1'b1, 1, "tff_press");
      applyRun(1'b0, 1, "tff_press");
      applyRun(1'b1, 8, "tff_press");
      applyRun(1'b0, 1, "tff_rel");
      applyRun(1'b1, 1, "tff_rel");
      applyRun(1'b0, 8, "tff_rel");
      checkBit("tff_after_press", tffQ, (p % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Random bouncy segments.
    for (int i = 0; i < 60; i++) begin
      logic lv;
      lv = 1'($urandom_range(0, 1));
      applyRun(lv, int'($urandom_range(1, 8)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
